// File: rtl/dm_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : dm_store_unit
// Purpose  : Memory-stage data-memory unit. It accepts one load or store per
//            cycle from M. Stores get byte enables and lane-aligned data and
//            are written into an internal word RAM. Loads return the raw,
//            unextended word one cycle later, with the byte offset and the op
//            for the W-stage extension logic. Misaligned and out-of-range
//            accesses raise AdEL or AdES.
// Ports    : clk, reset (async, active-high)
//            req_valid/req_we/req_op/addr/wdata/pc_in : M-stage request
//            rvalid/rdata_raw/a_low/op_out            : registered load result
//            exc_valid/exc_code/exc_pc                : registered exception
//            m_byteen/m_waddr/m_wdata                 : combinational store trace
// Revision : 1.0 - initial release
// ============================================================================
module dm_store_unit #(
  parameter int DEPTH_WORDS = 3072,
  parameter int AW          = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc_in,
  output logic        rvalid,
  output logic [31:0] rdata_raw,
  output logic [1:0]  a_low,
  output logic [2:0]  op_out,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_pc,
  output logic [3:0]  m_byteen,
  output logic [31:0] m_waddr,
  output logic [31:0] m_wdata
);

  localparam logic [2:0]  OP_WORD     = 3'd1;
  localparam logic [2:0]  OP_HALF     = 3'd2;
  localparam logic [2:0]  OP_BYTE     = 3'd3;
  localparam logic [4:0]  EXC_NONE    = 5'd0;
  localparam logic [4:0]  EXC_ADEL    = 5'd4;
  localparam logic [4:0]  EXC_ADES    = 5'd5;
  localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);
  localparam logic [AW:0] DEPTH_IDX   = (AW+1)'(DEPTH_WORDS);

  // Word RAM; contents survive reset.
  logic [31:0] mem [DEPTH_WORDS];

  logic          accepted;
  logic          misaligned;
  logic          out_of_range;
  logic          fault;
  logic          store_ok;
  logic          load_ok;
  logic [AW-1:0] widx;
  logic [3:0]    byteen;
  logic [31:0]   lane_data;
  logic [31:0]   rd_word;

  logic        rvalid_d,    rvalid_q;
  logic [31:0] rdata_d,     rdata_q;
  logic [1:0]  a_low_d,     a_low_q;
  logic [2:0]  op_d,        op_q;
  logic        exc_valid_d, exc_valid_q;
  logic [4:0]  exc_code_d,  exc_code_q;
  logic [31:0] exc_pc_d,    exc_pc_q;

  // --------------------------------------------------------------------------
  // Request decode and error detection
  // --------------------------------------------------------------------------
  always_comb begin
    accepted     = req_valid && (req_op == OP_WORD || req_op == OP_HALF ||
                                 req_op == OP_BYTE);
    misaligned   = ((req_op == OP_WORD) && (addr[1:0] != 2'b00)) ||
                   ((req_op == OP_HALF) && addr[0]);
    out_of_range = (addr[31:2] >= DEPTH_LIMIT);
    fault        = accepted && (misaligned || out_of_range);
    // Gating with reset keeps the RAM and the trace quiet during reset.
    store_ok     = accepted && req_we && !fault && !reset;
    load_ok      = accepted && !req_we && !fault;
    widx         = addr[AW+1:2];
  end

  // --------------------------------------------------------------------------
  // Store lane steering: replicate the right-justified data across all lanes
  // so the byte enables alone pick which lane lands in RAM.
  // --------------------------------------------------------------------------
  always_comb begin
    byteen    = 4'b0000;
    lane_data = 32'h0;
    case (req_op)
      OP_WORD: begin
        byteen    = 4'b1111;
        lane_data = wdata;
      end
      OP_HALF: begin
        byteen    = 4'b0011 << addr[1:0];
        lane_data = {2{wdata[15:0]}};
      end
      OP_BYTE: begin
        byteen    = 4'b0001 << addr[1:0];
        lane_data = {4{wdata[7:0]}};
      end
      default: begin
        byteen    = 4'b0000;
        lane_data = 32'h0;
      end
    endcase
  end

  assign m_byteen = store_ok ? byteen : 4'b0000;
  assign m_waddr  = store_ok ? {addr[31:2], 2'b00} : 32'h0;
  assign m_wdata  = store_ok ? lane_data : 32'h0;

  // --------------------------------------------------------------------------
  // RAM write port. A store in cycle N lands at the end of N, so a load in
  // N+1 reads the merged word through the combinational read below.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (store_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (byteen[b]) begin
          mem[widx][b*8 +: 8] <= lane_data[b*8 +: 8];
        end
      end
    end
  end

  // Guard the read so indices past the end of the array are never used.
  always_comb begin
    rd_word = 32'h0;
    if ({1'b0, widx} < DEPTH_IDX) begin
      rd_word = mem[widx];
    end
  end

  // --------------------------------------------------------------------------
  // Next-state for the registered load result and exception outputs
  // --------------------------------------------------------------------------
  always_comb begin
    rvalid_d    = 1'b0;
    rdata_d     = rdata_q;
    a_low_d     = a_low_q;
    op_d        = op_q;
    exc_valid_d = 1'b0;
    exc_code_d  = EXC_NONE;
    exc_pc_d    = 32'h0;

    if (load_ok) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
      a_low_d  = addr[1:0];
      op_d     = req_op;
    end

    if (fault) begin
      // A faulting access never exposes stale data to W.
      rdata_d     = 32'h0;
      exc_valid_d = 1'b1;
      exc_code_d  = req_we ? EXC_ADES : EXC_ADEL;
      exc_pc_d    = pc_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_q    <= 1'b0;
      rdata_q     <= 32'h0;
      a_low_q     <= 2'b00;
      op_q        <= 3'b000;
      exc_valid_q <= 1'b0;
      exc_code_q  <= EXC_NONE;
      exc_pc_q    <= 32'h0;
    end else begin
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      a_low_q     <= a_low_d;
      op_q        <= op_d;
      exc_valid_q <= exc_valid_d;
      exc_code_q  <= exc_code_d;
      exc_pc_q    <= exc_pc_d;
    end
  end

  assign rvalid    = rvalid_q;
  assign rdata_raw = rdata_q;
  assign a_low     = a_low_q;
  assign op_out    = op_q;
  assign exc_valid = exc_valid_q;
  assign exc_code  = exc_code_q;
  assign exc_pc    = exc_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_store_unit
// Purpose  : Self-checking bench for dm_store_unit, with directed scenarios
//            and randomized traffic checked against a byte-level memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] pc_in;
  logic        rvalid;
  logic [31:0] rdata_raw;
  logic [1:0]  a_low;
  logic [2:0]  op_out;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic [3:0]  m_byteen;
  logic [31:0] m_waddr;
  logic [31:0] m_wdata;

  dm_store_unit #(.DEPTH_WORDS(3072), .AW(12)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_op(req_op), .addr(addr), .wdata(wdata), .pc_in(pc_in),
    .rvalid(rvalid), .rdata_raw(rdata_raw), .a_low(a_low), .op_out(op_out),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .m_byteen(m_byteen), .m_waddr(m_waddr), .m_wdata(m_wdata)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: word store keyed by word index, plus expected outputs.
  logic [31:0] mm [int];
  logic [3:0]  e_be;
  logic [31:0] e_wa, e_wd;
  logic        e_rvalid;
  logic [31:0] e_rdata;
  logic [1:0]  e_alow;
  logic [2:0]  e_op;
  logic        e_exv;
  logic [4:0]  e_code;
  logic [31:0] e_pc;

  wire [75:0] got_reg = {rvalid, rdata_raw, a_low, op_out, exc_valid, exc_code, exc_pc};
  wire [75:0] exp_reg = {e_rvalid, e_rdata, e_alow, e_op, e_exv, e_code, e_pc};
  wire [67:0] got_tr  = {m_byteen, m_waddr, m_wdata};
  wire [67:0] exp_tr  = {e_be, e_wa, e_wd};

  task automatic clear_expect();
    e_be = 0; e_wa = 0; e_wd = 0;
    e_rvalid = 0; e_rdata = 0; e_alow = 0; e_op = 0;
    e_exv = 0; e_code = 0; e_pc = 0;
  endtask

  // Drives one request at the falling edge and advances the model by the
  // access rules: size-based alignment, word-range check, byte-lane merge.
  task automatic drive(input logic v, input logic we, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] pc);
    int size;
    int idx;
    bit acc;
    bit err;
    logic [31:0] w;
    @(negedge clk);
    req_valid = v; req_we = we; req_op = op; addr = a; wdata = d; pc_in = pc;
    acc  = v && (op >= 3'd1) && (op <= 3'd3);
    size = (op == 3'd1) ? 4 : (op == 3'd2) ? 2 : 1;
    err  = acc && (((a % size) != 0) || ((a >> 2) >= 3072));
    idx  = int'(a >> 2);
    e_be = 0; e_wa = 0; e_wd = 0;
    if (acc && we && !err) begin
      e_be = 4'(((1 << size) - 1) << (a % 4));
      e_wa = a & ~32'd3;
      e_wd = (size == 4) ? d : (size == 2) ? {2{d[15:0]}} : {4{d[7:0]}};
      w = mm.exists(idx) ? mm[idx] : 32'h0;
      for (int b = 0; b < size; b++) begin
        w[((a % 4) + b) * 8 +: 8] = d[b*8 +: 8];
      end
      mm[idx] = w;
    end
    if (acc && !we && !err) begin
      e_rvalid = 1; e_rdata = mm[idx]; e_alow = a[1:0]; e_op = op;
    end else begin
      e_rvalid = 0;
      if (err) e_rdata = 0;
    end
    e_exv  = err;
    e_code = err ? (we ? 5'd5 : 5'd4) : 5'd0;
    e_pc   = err ? pc : 32'h0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; req_valid = 0; req_we = 0; req_op = 0; addr = 0; wdata = 0; pc_in = 0;
    clear_expect();
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (got_reg !== 76'h0) begin errors++; $display("FAIL reset_reg got %h exp 0", got_reg); end
    checks++;
    if (got_tr !== 68'h0) begin errors++; $display("FAIL reset_trace got %h exp 0", got_tr); end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_word();
    drive(1, 1, 3'd1, 32'h10, 32'h11223344, 32'h1000);
    checks++;
    if (got_tr !== exp_tr) begin errors++; $display("FAIL sw_trace got %h exp %h", got_tr, exp_tr); end
    checks++;
    if (m_byteen !== 4'b1111) begin errors++; $display("FAIL sw_byteen got %b exp 1111", m_byteen); end
    tick();
    checks++;
    if (got_reg !== exp_reg) begin errors++; $display("FAIL sw_reg got %h exp %h", got_reg, exp_reg); end
    drive(1, 0, 3'd1, 32'h10, 32'h0, 32'h1004);
    tick();
    checks++;
    if (got_reg !== exp_reg) begin errors++; $display("FAIL lw_reg got %h exp %h", got_reg, exp_reg); end
    checks++;
    if (rdata_raw !== 32'h11223344) begin errors++; $display("FAIL lw_rdata got %h exp 11223344", rdata_raw); end
  endtask

  task automatic test_byte();
    drive(1, 1, 3'd3, 32'h13, 32'h000000AA, 32'h1008);
    checks++;
    if (got_tr !== exp_tr) begin errors++; $display("FAIL sb_trace got %h exp %h", got_tr, exp_tr); end
    checks++;
    if ({m_byteen, m_wdata} !== {4'b1000, 32'hAAAAAAAA}) begin
      errors++; $display("FAIL sb_lanes got %b/%h exp 1000/aaaaaaaa", m_byteen, m_wdata);
    end
    tick();
    drive(1, 0, 3'd1, 32'h10, 32'h0, 32'h100c);
    tick();
    checks++;
    if (got_reg !== exp_reg) begin errors++; $display("FAIL sb_lw_reg got %h exp %h", got_reg, exp_reg); end
    checks++;
    if (rdata_raw !== 32'hAA223344) begin errors++; $display("FAIL sb_rdata got %h exp aa223344", rdata_raw); end
  endtask

  task automatic test_half();
    drive(1, 1, 3'd2, 32'h12, 32'h0000BEEF, 32'h1010);
    checks++;
    if (got_tr !== exp_tr) begin errors++; $display("FAIL sh_trace got %h exp %h", got_tr, exp_tr); end
    tick();
    drive(1, 0, 3'd2, 32'h12, 32'h0, 32'h1014);
    tick();
    checks++;
    if (got_reg !== exp_reg) begin errors++; $display("FAIL lh_reg got %h exp %h", got_reg, exp_reg); end
    checks++;
    if ({rdata_raw, a_low, op_out} !== {32'hBEEF3344, 2'd2, 3'd2}) begin
      errors++; $display("FAIL lh_fields got %h/%0d/%0d exp beef3344/2/2", rdata_raw, a_low, op_out);
    end
  endtask

  task automatic test_addr_err();
    drive(1, 1, 3'd1, 32'h4, 32'hCAFEF00D, 32'h2000);
    tick();
    drive(1, 0, 3'd1, 32'h6, 32'h0, 32'h3008);
    tick();
    checks++;
    if (got_reg !== exp_reg) begin errors++; $display("FAIL adel_reg got %h exp %h", got_reg, exp_reg); end
    checks++;
    if ({exc_valid, exc_code, exc_pc, rvalid} !== {1'b1, 5'd4, 32'h3008, 1'b0}) begin
      errors++; $display("FAIL adel_fields got %b/%0d/%h/%b exp 1/4/3008/0", exc_valid, exc_code, exc_pc, rvalid);
    end
    drive(1, 1, 3'd2, 32'h5, 32'h00001234, 32'h300c);
    checks++;
    if (got_tr !== exp_tr) begin errors++; $display("FAIL ades_trace got %h exp %h", got_tr, exp_tr); end
    tick();
    checks++;
    if (got_reg !== exp_reg) begin errors++; $display("FAIL ades_reg got %h exp %h", got_reg, exp_reg); end
    drive(1, 0, 3'd1, 32'h4, 32'h0, 32'h3010);
    tick();
    checks++;
    if (got_reg !== exp_reg) begin errors++; $display("FAIL ades_nowrite got %h exp %h", got_reg, exp_reg); end
    // Ignored op: no write, no result, no exception.
    drive(1, 1, 3'd0, 32'h4, 32'hFFFFFFFF, 32'h3014);
    checks++;
    if (got_tr !== exp_tr) begin errors++; $display("FAIL noop_trace got %h exp %h", got_tr, exp_tr); end
    tick();
    checks++;
    if (got_reg !== exp_reg) begin errors++; $display("FAIL noop_reg got %h exp %h", got_reg, exp_reg); end
  endtask

  task automatic test_range();
    drive(1, 1, 3'd1, 32'h3000, 32'h55555555, 32'h4000);
    checks++;
    if (got_tr !== exp_tr) begin errors++; $display("FAIL range_trace got %h exp %h", got_tr, exp_tr); end
    tick();
    checks++;
    if (got_reg !== exp_reg) begin errors++; $display("FAIL range_reg got %h exp %h", got_reg, exp_reg); end
    drive(1, 1, 3'd1, 32'h2FFC, 32'h5A5A1234, 32'h4004);
    checks++;
    if (got_tr !== exp_tr) begin errors++; $display("FAIL edge_trace got %h exp %h", got_tr, exp_tr); end
    tick();
    drive(1, 0, 3'd1, 32'h2FFC, 32'h0, 32'h4008);
    tick();
    checks++;
    if (got_reg !== exp_reg) begin errors++; $display("FAIL edge_lw got %h exp %h", got_reg, exp_reg); end
    drive(1, 0, 3'd3, 32'h3001, 32'h0, 32'h400c);
    tick();
    checks++;
    if (got_reg !== exp_reg) begin errors++; $display("FAIL range_adel got %h exp %h", got_reg, exp_reg); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] old;
    drive(1, 0, 3'd1, 32'h10, 32'h0, 32'h5000);
    tick();
    old = mm[4];
    drive(1, 1, 3'd1, 32'h10, 32'hDEADBEEF, 32'h5004);
    reset = 1;
    #1;
    checks++;
    if (got_reg !== 76'h0) begin errors++; $display("FAIL midrst_reg got %h exp 0", got_reg); end
    checks++;
    if (got_tr !== 68'h0) begin errors++; $display("FAIL midrst_trace got %h exp 0", got_tr); end
    tick();
    checks++;
    if (got_reg !== 76'h0) begin errors++; $display("FAIL midrst_hold got %h exp 0", got_reg); end
    @(negedge clk);
    reset = 0; req_valid = 0;
    mm[4] = old;
    clear_expect();
    drive(1, 0, 3'd1, 32'h10, 32'h0, 32'h5008);
    tick();
    checks++;
    if (got_reg !== exp_reg) begin errors++; $display("FAIL midrst_lw got %h exp %h", got_reg, exp_reg); end
  endtask

  task automatic test_random();
    int r;
    int widx;
    logic [2:0] op;
    logic [31:0] a;
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 3'd1, 32'(256 + i * 4), $urandom, 32'h6000);
      tick();
    end
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom % 11);
      if (r < 8)       widx = 64 + r;
      else if (r == 8) widx = 3071;
      else if (r == 9) widx = 3072 + int'($urandom % 5000);
      else             widx = -1;
      if (widx < 0) a = $urandom | 32'h8000_0000;
      else          a = 32'(widx * 4) + 32'($urandom % 4);
      r = int'($urandom % 10);
      op = (r < 3) ? 3'd1 : (r < 6) ? 3'd2 : (r < 9) ? 3'd3 : 3'($urandom % 8);
      drive(($urandom % 4) != 0, $urandom % 2 == 1, op, a, $urandom, $urandom);
      checks++;
      if (got_tr !== exp_tr) begin errors++; $display("FAIL rand_trace n=%0d got %h exp %h", n, got_tr, exp_tr); end
      tick();
      checks++;
      if (got_reg !== exp_reg) begin errors++; $display("FAIL rand_reg n=%0d got %h exp %h", n, got_reg, exp_reg); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_addr_err();
    test_range();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
